// File: rtl/lemmings_dig_arbiter.sv
// Round-robin arbiter granting one shared digger to four lemmings for a bounded dig.
// Optional saturating abort counter enabled by macro LEMMINGS_ABORT_CNT_EN.
module lemmings_dig_arbiter #(
    parameter int unsigned DIG_CYCLES = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       areset,
    input  logic [3:0] dig_req,
    input  logic [3:0] ground,
    output logic [3:0] grant,
    output logic       busy,
    output logic       dig_done,
    output logic       dig_abort,
    output logic [7:0] abort_cnt
);

    localparam int unsigned N_LEM = 4;
    localparam int unsigned IDX_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG  = 2'd1,
        COOL = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [N_LEM-1:0]   grant_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               abort_nxt;

    logic [N_LEM-1:0]   eligible;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;

    assign eligible = dig_req & ground;

    // First eligible index starting at ptr; scanning backwards lets the nearest one win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr;
        for (int k = N_LEM - 1; k >= 0; k--) begin
            if (eligible[ptr + IDX_W'(k)]) begin
                pick_vld = 1'b1;
                pick_idx = ptr + IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        grant_nxt = '0;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = DIG;
                    owner_nxt = pick_idx;
                    cnt_nxt   = '0;
                    grant_nxt = N_LEM'(1) << pick_idx;
                end
            end
            DIG: begin
                // Lost ground beats release and completion; only the owner's inputs matter.
                if (!ground[owner] || !dig_req[owner] || (cnt == CNT_LAST)) begin
                    state_nxt = COOL;
                    ptr_nxt   = owner + IDX_W'(1);
                    abort_nxt = !ground[owner];
                    done_nxt  = ground[owner] && dig_req[owner];
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    grant_nxt = grant;
                end
            end
            COOL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == DIG);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            dig_done  <= 1'b0;
            dig_abort <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            cnt       <= cnt_nxt;
            grant     <= grant_nxt;
            busy      <= busy_nxt;
            dig_done  <= done_nxt;
            dig_abort <= abort_nxt;
        end
    end

`ifdef LEMMINGS_ABORT_CNT_EN
    logic [7:0] abort_cnt_q;

    // Counts in step with the dig_abort pulse, sticking at 255.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            abort_cnt_q <= '0;
        end else if (abort_nxt && (abort_cnt_q != 8'hFF)) begin
            abort_cnt_q <= abort_cnt_q + 8'd1;
        end
    end

    assign abort_cnt = abort_cnt_q;
`else
    assign abort_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_lemmings_dig_arbiter.sv
// Bench for lemmings_dig_arbiter: vector table, directed corner sequences and
// randomized traffic against a cycle-level ownership model.
module tb_lemmings_dig_arbiter;

    localparam int DIG_CYCLES = 8;

    logic       clk = 1'b0;
    logic       areset;
    logic [3:0] dig_req;
    logic [3:0] ground;
    logic [3:0] grant;
    logic       busy;
    logic       dig_done;
    logic       dig_abort;
    logic [7:0] abort_cnt;

    always #5 clk = ~clk;

    lemmings_dig_arbiter #(.DIG_CYCLES(DIG_CYCLES), .CNT_W(4)) dut (
        .clk(clk), .areset(areset), .dig_req(dig_req), .ground(ground),
        .grant(grant), .busy(busy), .dig_done(dig_done),
        .dig_abort(dig_abort), .abort_cnt(abort_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: who owns the digger, how long they have held it, and a one-cycle cooldown.
    int m_owner;
    int m_held;
    int m_ptr;
    int m_abcnt;
    bit m_cool;
    bit m_done;
    bit m_abort;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnd;
        logic [3:0] exp_grant;
        logic       exp_done;
        logic       exp_abort;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_ptr = 0; m_abcnt = 0;
        m_cool = 0; m_done = 0; m_abort = 0;
    endtask

    task automatic model_step();
        bit ending;
        ending  = 0;
        m_done  = 0;
        m_abort = 0;
        if (m_cool) begin
            m_cool = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && dig_req[(m_ptr + k) % 4] && ground[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_held  = 1;
                end
            end
        end else begin
            if (!ground[m_owner]) begin
                m_abort = 1; ending = 1;
            end else if (!dig_req[m_owner]) begin
                ending = 1;
            end else if (m_held == DIG_CYCLES) begin
                m_done = 1; ending = 1;
            end else begin
                m_held++;
            end
            if (ending) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_cool  = 1;
`ifdef LEMMINGS_ABORT_CNT_EN
                if (m_abort && m_abcnt < 255) m_abcnt++;
`endif
            end
        end
    endtask

    task automatic compare_model(input string tag);
        logic [3:0] eg;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        check({tag, "_grant"}, 8'(grant), 8'(eg));
        check({tag, "_busy"}, 8'(busy), 8'(m_owner >= 0));
        check({tag, "_done"}, 8'(dig_done), 8'(m_done));
        check({tag, "_abort"}, 8'(dig_abort), 8'(m_abort));
        check({tag, "_abcnt"}, abort_cnt, 8'(m_abcnt));
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        areset  = 1'b1;
        dig_req = 4'h0;
        ground  = 4'hF;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model("reset");
        areset = 1'b0;
    endtask

    task automatic req_hold_rr(input logic [3:0] req, input int n_grants, input string tag);
        logic [3:0] exp_g;
        int         idx;
        dig_req = req;
        ground  = 4'hF;
        idx     = 0;
        for (int g = 0; g < n_grants; g++) begin
            while (!req[idx]) idx = (idx + 1) % 4;
            exp_g = 4'(1 << idx);
            for (int c = 0; c < DIG_CYCLES; c++) begin
                step(tag);
                check({tag, "_grant"}, 8'(grant), 8'(exp_g));
            end
            step(tag);
            check({tag, "_done"}, 8'(dig_done), 8'd1);
            step(tag);
            check({tag, "_idle"}, 8'(grant), 8'd0);
            idx = (idx + 1) % 4;
        end
    endtask

    initial begin
        areset  = 1'b1;
        dig_req = 4'h0;
        ground  = 4'hF;
        model_reset();

        // Vector table: ground gating, non-owner noise, abort beating completion, rotation.
        vecs.push_back('{4'b0010, 4'b1101, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{4'b0010, 4'b1101, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{4'b0010, 4'b1111, 4'b0010, 1'b0, 1'b0});
        vecs.push_back('{4'b1111, 4'b0111, 4'b0010, 1'b0, 1'b0});
        for (int i = 0; i < 6; i++) vecs.push_back('{4'b0010, 4'b1111, 4'b0010, 1'b0, 1'b0});
        vecs.push_back('{4'b0010, 4'b1101, 4'b0000, 1'b0, 1'b1});
        vecs.push_back('{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0});
        for (int i = 0; i < 8; i++) vecs.push_back('{4'b0101, 4'b1111, 4'b0100, 1'b0, 1'b0});
        vecs.push_back('{4'b0101, 4'b1111, 4'b0000, 1'b1, 1'b0});
        vecs.push_back('{4'b0101, 4'b1111, 4'b0000, 1'b0, 1'b0});
        vecs.push_back('{4'b0101, 4'b1111, 4'b0001, 1'b0, 1'b0});

        do_reset();
        foreach (vecs[i]) begin
            dig_req = vecs[i].req;
            ground  = vecs[i].gnd;
            step("vecmodel");
            check($sformatf("vec%0d_grant", i), 8'(grant), 8'(vecs[i].exp_grant));
            check($sformatf("vec%0d_busy", i), 8'(busy), 8'(|vecs[i].exp_grant));
            check($sformatf("vec%0d_done", i), 8'(dig_done), 8'(vecs[i].exp_done));
            check($sformatf("vec%0d_abort", i), 8'(dig_abort), 8'(vecs[i].exp_abort));
        end

        do_reset();
        req_hold_rr(4'b0101, 2, "pair");
        do_reset();
        req_hold_rr(4'b1111, 5, "rr");

        // Owner 2 loses ground at cnt=3; next winner must be lemming 3.
        do_reset();
        dig_req = 4'b0100;
        step("ab");
        repeat (3) step("ab");
        ground = 4'b1011;
        step("ab");
        check("ab_grant", 8'(grant), 8'd0);
        check("ab_pulse", 8'(dig_abort), 8'd1);
        check("ab_nodone", 8'(dig_done), 8'd0);
`ifdef LEMMINGS_ABORT_CNT_EN
        check("ab_cnt", abort_cnt, 8'd1);
`else
        check("ab_cnt", abort_cnt, 8'd0);
`endif
        dig_req = 4'hF;
        ground  = 4'hF;
        step("ab");
        step("ab");
        check("ab_ptr3", 8'(grant), 8'b1000);

        // Owner 1 releases at cnt=5: silent exit, next winner lemming 2.
        do_reset();
        dig_req = 4'b0010;
        step("rel");
        repeat (5) step("rel");
        dig_req = 4'b0000;
        step("rel");
        check("rel_grant", 8'(grant), 8'd0);
        check("rel_pulses", 8'({dig_done, dig_abort}), 8'd0);
        dig_req = 4'hF;
        step("rel");
        step("rel");
        check("rel_ptr2", 8'(grant), 8'b0100);

        // Reset mid-dig at cnt=4 clears outputs at once and restarts the pointer.
        do_reset();
        dig_req = 4'b0010;
        repeat (DIG_CYCLES + 2) step("mid");
        dig_req = 4'b0100;
        step("mid");
        repeat (4) step("mid");
        check("mid_owner", 8'(grant), 8'b0100);
        areset = 1'b1;
        #1;
        check("mid_grant", 8'(grant), 8'd0);
        check("mid_busy", 8'(busy), 8'd0);
        check("mid_pulses", 8'({dig_done, dig_abort}), 8'd0);
        do_reset();
        dig_req = 4'hF;
        step("mid");
        check("mid_ptr0", 8'(grant), 8'b0001);

        // Randomized traffic with occasional ground loss.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) dig_req = 4'($urandom);
            ground = 4'hF;
            if ($urandom_range(0, 9) == 0) ground[2'($urandom_range(0, 3))] = 1'b0;
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
